// File: rtl/eret_return_ctrl.sv
// eret_return_ctrl: exception-return sequencer, which tracks nesting depth and runs ERET
// through flush, drain, redirect and EPC restore (or EXL clear).
module eret_return_ctrl #(
    parameter int MAX_DEPTH     = 2,
    parameter int DEPTH_W       = 2,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               eret_req_i,
    input  logic               exc_enter_i,
    input  logic [31:0]        epc_data_i,
    input  logic               drain_ack_i,
    input  logic               redirect_ready_i,
    output logic               flush_o,
    output logic               redirect_valid_o,
    output logic [31:0]        redirect_pc_o,
    output logic               epc_restore_o,
    output logic               nepc_pop_o,
    output logic               exl_clear_o,
    output logic               busy_o,
    output logic [DEPTH_W-1:0] depth_o,
    output logic               underflow_err_o,
    output logic               overflow_err_o,
    output logic               drain_timeout_o
);
    localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, FLUSH, DRAIN, REDIRECT, RESTORE} state_t;
    state_t state_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [CW-1:0] cnt_q;
    logic [31:0] ret_pc_q;
    logic flush_q, rv_q, restore_q, exl_q, uf_q, of_q, to_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            depth_q   <= '0;
            cnt_q     <= '0;
            ret_pc_q  <= '0;
            flush_q   <= 1'b0;
            rv_q      <= 1'b0;
            restore_q <= 1'b0;
            exl_q     <= 1'b0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            flush_q   <= 1'b0;
            restore_q <= 1'b0;
            exl_q     <= 1'b0;
            uf_q      <= 1'b0;
            of_q      <= 1'b0;
            to_q      <= 1'b0;
            if (exc_enter_i) begin
                if (depth_q < DEPTH_W'(MAX_DEPTH)) depth_q <= depth_q + DEPTH_W'(1);
                else of_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (eret_req_i && !exc_enter_i) begin
                    if (depth_q != '0) begin
                        ret_pc_q <= epc_data_i;
                        flush_q  <= 1'b1;
                        state_q  <= FLUSH;
                    end else begin
                        uf_q <= 1'b1;
                    end
                end
                FLUSH: begin
                    cnt_q   <= '0;
                    state_q <= exc_enter_i ? IDLE : DRAIN;
                end
                DRAIN: begin
                    if (exc_enter_i) begin
                        state_q <= IDLE;
                    end else if (drain_ack_i || cnt_q == CW'(DRAIN_TIMEOUT - 1)) begin
                        to_q    <= !drain_ack_i;
                        rv_q    <= 1'b1;
                        state_q <= REDIRECT;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                REDIRECT: begin
                    // an exception in the same cycle wins over the handshake
                    if (exc_enter_i) begin
                        rv_q    <= 1'b0;
                        state_q <= IDLE;
                    end else if (redirect_ready_i) begin
                        rv_q      <= 1'b0;
                        depth_q   <= depth_q - DEPTH_W'(1);
                        restore_q <= depth_q > DEPTH_W'(1);
                        exl_q     <= depth_q <= DEPTH_W'(1);
                        state_q   <= depth_q > DEPTH_W'(1) ? RESTORE : IDLE;
                    end
                end
                RESTORE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign flush_o          = flush_q;
    assign redirect_valid_o = rv_q;
    assign redirect_pc_o    = rv_q ? ret_pc_q : 32'h0;
    assign epc_restore_o    = restore_q;
    assign nepc_pop_o       = restore_q;
    assign exl_clear_o      = exl_q;
    assign busy_o           = state_q != IDLE;
    assign depth_o          = depth_q;
    assign underflow_err_o  = uf_q;
    assign overflow_err_o   = of_q;
    assign drain_timeout_o  = to_q;
endmodule

// File: tb/tb_eret_return_ctrl.sv
// tb_eret_return_ctrl: vector table and hand sequences, with expected outputs queued at drive
// time and checked one clock later.
module tb_eret_return_ctrl;
    logic clk = 1'b0, rst = 1'b1, eret_req = 1'b0, exc_enter = 1'b0, drain_ack = 1'b0, redirect_ready = 1'b0;
    logic [31:0] epc_data = 32'h0;
    logic flush, redirect_valid, epc_restore, nepc_pop, exl_clear, busy, underflow_err, overflow_err, drain_timeout;
    logic [31:0] redirect_pc;
    logic [1:0] depth;

    eret_return_ctrl dut (
        .clk(clk), .rst(rst), .eret_req_i(eret_req), .exc_enter_i(exc_enter), .epc_data_i(epc_data),
        .drain_ack_i(drain_ack), .redirect_ready_i(redirect_ready), .flush_o(flush),
        .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .epc_restore_o(epc_restore),
        .nepc_pop_o(nepc_pop), .exl_clear_o(exl_clear), .busy_o(busy), .depth_o(depth),
        .underflow_err_o(underflow_err), .overflow_err_o(overflow_err), .drain_timeout_o(drain_timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0]  f;
        logic [1:0]  d;
        logic [31:0] pc;
    } out_t;
    typedef struct {
        string       name;
        logic [4:0]  in;
        logic [31:0] epc;
        out_t        expv;
    } vec_t;

    // input bits: rst eret exc ack rdy
    localparam logic [4:0] I = 5'b00000, R = 5'b10000, E = 5'b01000, X = 5'b00100, A = 5'b00010, Y = 5'b00001;
    // flag bits: flush rv restore pop exl busy uf of to
    localparam logic [8:0] N = 9'b000000000, B = 9'b000001000, FL = 9'b100001000, RV = 9'b010001000,
                           EX = 9'b000010000, RS = 9'b001101000, UF = 9'b000000100, OF = 9'b000000010,
                           TO = 9'b010001001;

    vec_t vecs[$];
    out_t sb[$];
    out_t act;
    int applied = 0, miscompares = 0;

    assign act = '{f: {flush, redirect_valid, epc_restore, nepc_pop, exl_clear, busy, underflow_err, overflow_err,
                       drain_timeout}, d: depth, pc: redirect_pc};

    function automatic vec_t mk(string n, logic [4:0] in, logic [31:0] epc, logic [8:0] f, logic [1:0] d,
                                logic [31:0] pc);
        vec_t v;
        v.name = n; v.in = in; v.epc = epc; v.expv = '{f: f, d: d, pc: pc};
        return v;
    endfunction

    function automatic void add(string n, logic [4:0] in, logic [31:0] epc, logic [8:0] f, logic [1:0] d,
                                logic [31:0] pc);
        vecs.push_back(mk(n, in, epc, f, d, pc));
    endfunction

    task automatic step(vec_t v);
        out_t e;
        @(negedge clk);
        {rst, eret_req, exc_enter, drain_ack, redirect_ready} = v.in;
        epc_data = v.epc;
        sb.push_back(v.expv);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        applied++;
        if (act !== e) begin
            miscompares++;
            $display("FAIL %s: got flags=%b depth=%0d pc=%h, expected flags=%b depth=%0d pc=%h",
                     v.name, act.f, act.d, act.pc, e.f, e.d, e.pc);
        end
    endtask

    task automatic go(string n, logic [4:0] in, logic [31:0] epc, logic [8:0] f, logic [1:0] d, logic [31:0] pc);
        step(mk(n, in, epc, f, d, pc));
    endtask

    initial begin
        add("reset",          R,     0,            N,  0, 0);
        add("p1_exc",         X,     0,            N,  1, 0);
        add("p1_eret",        E,     32'h80000180, FL, 1, 0);
        add("p1_drain",       I,     0,            B,  1, 0);
        add("p1_redirect",    A,     0,            RV, 1, 32'h80000180);
        add("p1_exl_clear",   Y,     0,            EX, 0, 0);
        add("p1_idle",        I,     0,            N,  0, 0);
        add("p2_exc1",        X,     0,            N,  1, 0);
        add("p2_exc2",        X,     0,            N,  2, 0);
        add("p2_eret",        E|A|Y, 32'hBFC00200, FL, 2, 0);
        add("p2_drain",       A|Y,   0,            B,  2, 0);
        add("p2_redirect",    A|Y,   0,            RV, 2, 32'hBFC00200);
        add("p2_restore",     A|Y,   0,            RS, 1, 0);
        add("p2_idle",        I,     0,            N,  1, 0);
        add("p3_reset",       R,     0,            N,  0, 0);
        add("p3_underflow",   E,     32'h12345678, UF, 0, 0);
        add("p3_idle",        I,     0,            N,  0, 0);
        add("p5_exc",         X,     0,            N,  1, 0);
        add("p5_eret",        E,     32'hA0000000, FL, 1, 0);
        add("p5_drain",       I,     0,            B,  1, 0);
        add("p5_abort_drain", X,     0,            N,  2, 0);
        add("p5_idle",        I,     0,            N,  2, 0);
        add("p5_reset",       R,     0,            N,  0, 0);
        add("p5_exc",         X,     0,            N,  1, 0);
        add("p5_exc_eret",    X|E,   32'h11110000, N,  2, 0);
        add("p5_no_flush",    I,     0,            N,  2, 0);
        add("p6_reset",       R,     0,            N,  0, 0);
        add("p6_exc1",        X,     0,            N,  1, 0);
        add("p6_exc2",        X,     0,            N,  2, 0);
        add("p6_overflow",    X,     0,            OF, 2, 0);
        add("p6_idle",        I,     0,            N,  2, 0);
        add("p6_eret",        E,     32'hDEADBEEC, FL, 2, 0);
        add("p6_drain",       A,     0,            B,  2, 0);
        add("p6_redirect",    A,     0,            RV, 2, 32'hDEADBEEC);
        add("p6_rst_redir",   R,     0,            N,  0, 0);
        add("p6_after_rst",   I,     0,            N,  0, 0);
        foreach (vecs[k]) step(vecs[k]);

        // exception during RESTORE, eret while busy, then exception aborting REDIRECT at max depth
        go("rs_exc1",        X,     0,            N,  1, 0);
        go("rs_exc2",        X,     0,            N,  2, 0);
        go("rs_eret",        E,     32'h00000400, FL, 2, 0);
        go("rs_busy_eret",   E|A,   32'h0000DEAD, B,  2, 0);
        go("rs_redirect",    A,     0,            RV, 2, 32'h00000400);
        go("rs_restore",     Y,     0,            RS, 1, 0);
        go("rs_exc_restore", X,     0,            N,  2, 0);
        go("ab_eret",        E,     32'h00000500, FL, 2, 0);
        go("ab_drain",       I,     0,            B,  2, 0);
        go("ab_redirect",    A,     0,            RV, 2, 32'h00000500);
        go("ab_exc_ready",   X|Y,   0,            OF, 2, 0);
        go("ab_idle",        Y,     0,            N,  2, 0);

        // drain timeout followed by a redirect stalled by fetch
        go("to_reset",       R,     0,            N,  0, 0);
        go("to_exc",         X,     0,            N,  1, 0);
        go("to_eret",        E,     32'h9FC00000, FL, 1, 0);
        go("to_drain_first", I,     0,            B,  1, 0);
        for (int c = 1; c < 16; c++) go($sformatf("to_drain_%0d", c), I, 0, B, 1, 0);
        go("to_timeout",     I,     0,            TO, 1, 32'h9FC00000);
        for (int c = 0; c < 5; c++) go($sformatf("to_stall_%0d", c), I, 32'h0BADF00D, RV, 1, 32'h9FC00000);
        go("to_handshake",   Y,     0,            EX, 0, 0);
        go("to_idle",        I,     0,            N,  0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/eret_return_ctrl.md
Name: eret_return_ctrl

Overview:
Exception-return sequencer for CP0; consumes the values that the EPC and nested-EPC units capture on exception entry.
- Tracks exception nesting depth.
- On ERET: flushes the pipeline, waits for drain, redirects fetch to the saved EPC, then pops the nested EPC back into the primary EPC or clears EXL.
- Sits between the decode/mem-stage ERET detect, the two EPC registers and the fetch unit.

Parameters:
- MAX_DEPTH, 2, maximum tracked exception nesting level (depth saturates here).
- DEPTH_W, 2, width of the depth counter; must hold MAX_DEPTH.
- DRAIN_TIMEOUT, 16, maximum cycles spent waiting for drain_ack before forcing progress.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- eret_req  in  1  ERET committed this cycle (single-cycle pulse).
- exc_enter  in  1  hardware exception taken this cycle (single-cycle pulse).
- epc_data  in  32  read_data of the primary EPC unit.
- drain_ack  in  1  pipeline reports empty.
- redirect_ready  in  1  fetch accepts the redirect.
- flush  out  1  pipeline flush strobe.
- redirect_valid  out  1  redirect PC is valid.
- redirect_pc  out  32  return address.
- epc_restore  out  1  strobe to the primary EPC: load from the nested EPC.
- nepc_pop  out  1  strobe to the nested EPC: release its entry.
- exl_clear  out  1  strobe to the Status register: clear EXL.
- busy  out  1  high in any state other than IDLE.
- depth  out  DEPTH_W  current nesting depth.
- underflow_err  out  1  ERET issued with depth 0.
- overflow_err  out  1  exception taken while at MAX_DEPTH.
- drain_timeout  out  1  drain wait expired without drain_ack.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, depth=0, ret_pc=0, wait counter=0. All outputs 0, redirect_pc=0. Reset mid-sequence abandons the ERET with no strobes issued.
- Every strobe output (flush, epc_restore, nepc_pop, exl_clear, underflow_err, overflow_err, drain_timeout) is a 1-cycle registered pulse.
- exc_enter depth update, applied in any state:
  - depth<MAX_DEPTH: depth+1.
  - depth==MAX_DEPTH: depth unchanged; overflow_err pulses.
- IDLE:
  - exc_enter=1: stay IDLE. If eret_req is also 1, exception has priority and the ERET is discarded.
  - eret_req=1 and depth>0: ret_pc<=epc_data (sampled that cycle); go to FLUSH.
  - eret_req=1 and depth==0: underflow_err pulses; stay IDLE.
- FLUSH: flush=1 for exactly one cycle; wait counter cleared; go to DRAIN.
- DRAIN:
  - drain_ack=1: go to REDIRECT next cycle.
  - Otherwise the counter increments. When counter==DRAIN_TIMEOUT-1 without ack: drain_timeout pulses and go to REDIRECT.
- REDIRECT:
  - redirect_valid=1 and redirect_pc=ret_pc, held stable until redirect_ready=1 (valid/ready handshake; valid never drops before ready).
  - On handshake: depth-1. If the pre-decrement depth was >1, go to RESTORE. Otherwise exl_clear pulses the next cycle and go to IDLE.
- RESTORE: epc_restore=1 and nepc_pop=1 together for one cycle; go to IDLE.
- exc_enter during FLUSH, DRAIN or REDIRECT: ERET aborted and return to IDLE next cycle. No decrement, no redirect handshake counted, no restore/exl_clear; depth updated as above.
- exc_enter during RESTORE: the restore pulses still complete and depth is updated as above.
- eret_req while busy: ignored.
- redirect_pc is 0 whenever redirect_valid=0.
- Latency from eret_req to redirect_valid with immediate drain_ack: 3 cycles (FLUSH, DRAIN, REDIRECT).

Test Plan:
1. Reset, exc_enter once (depth=1), epc_data=0x8000_0180, eret_req:
   - flush pulses at T+1; drain_ack at T+2.
   - redirect_valid with redirect_pc=0x8000_0180 at T+3; redirect_ready=1.
   - depth=0, exl_clear pulses; no epc_restore.
2. Two exc_enter (depth=2), eret_req with epc_data=0xBFC0_0200, immediate ack/ready:
   - redirect_pc=0xBFC0_0200, depth=1.
   - Next cycle epc_restore=nepc_pop=1; exl_clear stays 0.
3. eret_req at depth 0: underflow_err one cycle, flush never asserted, busy=0.
4. drain_ack held 0: drain_timeout pulses after 16 DRAIN cycles, then REDIRECT. With redirect_ready low 5 cycles, redirect_valid/redirect_pc stay stable throughout.
5. exc_enter in DRAIN at depth=1: return to IDLE, depth=2, no redirect_valid/exl_clear. Separately, exc_enter+eret_req same cycle in IDLE: depth+1, no flush.
6. Three exc_enter with MAX_DEPTH=2: depth=2, overflow_err on the third. Then rst asserted mid-REDIRECT: all outputs 0, depth=0 next cycle.
